// File: rtl/johnson_slot_scheduler_pkg.sv
// Shared definitions for the Johnson-counter slot scheduler: sizes, FSM encoding,
// the legal ring codes and helpers to decode and validate them.
package johnson_slot_scheduler_pkg;

  localparam int JW    = 5;
  localparam int SLOTS = 2 * JW;
  localparam int SW    = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  // Index i of this table is slot i.
  localparam logic [JW-1:0] JCODES [SLOTS] = '{
    5'b00000, 5'b00001, 5'b00011, 5'b00111, 5'b01111,
    5'b11111, 5'b11110, 5'b11100, 5'b11000, 5'b10000
  };

  function automatic logic [SW-1:0] jdecode(input logic [JW-1:0] code);
    logic [SW-1:0] idx;
    idx = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (code == JCODES[i]) idx = SW'(i);
    end
    return idx;
  endfunction

  function automatic logic jlegal(input logic [JW-1:0] code);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      if (code == JCODES[i]) ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/johnson_ring_core.sv
// Twisted-ring counter with synchronous clear and self-correction of illegal codes;
// a corrected code raises a one-cycle illegal flag.
module johnson_ring_core
  import johnson_slot_scheduler_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          clr,
  output logic [JW-1:0] count,
  output logic          illegal
);

  logic [JW-1:0] ring_q;
  logic          illegal_q;

  // Correction outranks clear and step so an upset is always reported.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ring_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= !jlegal(ring_q);
      if (!jlegal(ring_q))
        ring_q <= '0;
      else if (clr)
        ring_q <= '0;
      else if (en)
        ring_q <= {ring_q[JW-2:0], ~ring_q[JW-1]};
    end
  end

  assign count   = ring_q;
  assign illegal = illegal_q;

endmodule

// File: rtl/johnson_slot_scheduler.sv
// Round-based slot scheduler: runs the Johnson ring for a programmed number of
// rounds and grants the shared resource to the requester owning the current slot.
module johnson_slot_scheduler
  import johnson_slot_scheduler_pkg::*;
#(
  parameter int RW = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [RW-1:0]    rounds,
  input  logic [SLOTS-1:0] req,
  output logic [JW-1:0]    count,
  output logic [SW-1:0]    slot,
  output logic [SLOTS-1:0] grant,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_e        state_q, state_d;
  logic [RW-1:0] remaining_q;
  logic [JW-1:0] count_w;
  logic          illegal_w;
  logic          accept, last_slot, ring_en, ring_clr;

  assign accept    = start && !stop && (rounds != '0);
  assign last_slot = (count_w == JCODES[SLOTS-1]);
  assign ring_en   = (state_q == ST_RUN);
  assign ring_clr  = (state_q != ST_RUN) || stop;

  johnson_ring_core u_core (
    .clk     (clk),
    .reset   (reset),
    .en      (ring_en),
    .clr     (ring_clr),
    .count   (count_w),
    .illegal (illegal_w)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // stop outranks completion, even on the last slot of the last round.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_RUN;
      ST_RUN: begin
        if (stop)
          state_d = ST_IDLE;
        else if (last_slot && (remaining_q == RW'(1)))
          state_d = ST_FINISH;
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      remaining_q <= '0;
    else if ((state_q == ST_IDLE) && accept)
      remaining_q <= rounds;
    else if ((state_q == ST_RUN) && !stop && last_slot && (remaining_q > RW'(1)))
      remaining_q <= remaining_q - RW'(1);
  end

  assign count = count_w;
  assign slot  = jdecode(count_w);
  assign err   = illegal_w;

  always_comb begin
    busy  = 1'b0;
    done  = 1'b0;
    grant = '0;
    case (state_q)
      ST_RUN: begin
        busy  = 1'b1;
        grant = (SLOTS'(1) << slot) & req;
      end
      ST_FINISH: done = 1'b1;
      default: ;
    endcase
  end

endmodule
